tcdm_cmd_arbiter: RTL and testbench
===================================

// Module: tcdm_cmd_arbiter
// PURPOSE
//  Shares one TCDM command unpacker between NB_PORTS command sources (e.g. TX and RX command queues).
//  Selects one requester per command: round-robin by default, fixed priority when the macro is set.
//  Forwards the winner's opc/len/add/sid to the unpacker.
//  Tracks the in-flight transaction until its end-of-packet beat and pulses a per-port done flag.
//  Sits between the mchan command queues and the TCDM beat unpacker.
// PARAMETERS
//  NB_PORTS        2   number of command requesters (>=2)
//  TRANS_SID_WIDTH 2   transaction id width
//  TCDM_ADD_WIDTH  12  TCDM address width
//  TCDM_OPC_WIDTH  12  opcode width
//  MCHAN_LEN_WIDTH 15  transfer length width (bytes)
// PORTS
//  clk_i         in   1                     clock
//  rst_ni        in   1                     asynchronous reset, active-low
//  in_opc_i      in   [NB_PORTS][OPC]       per-port command opcode
//  in_len_i      in   [NB_PORTS][LEN]       per-port command length
//  in_add_i      in   [NB_PORTS][ADD]       per-port TCDM start address
//  in_sid_i      in   [NB_PORTS][SID]       per-port transaction id
//  in_req_i      in   NB_PORTS              per-port command valid
//  in_gnt_o      out  NB_PORTS              per-port command accepted (one-hot or zero)
//  cmd_opc_o     out  OPC                   selected opcode to unpacker
//  cmd_len_o     out  LEN                   selected length
//  cmd_add_o     out  ADD                   selected address
//  cmd_sid_o     out  SID                   selected sid
//  cmd_req_o     out  1                     command valid to unpacker
//  cmd_gnt_i     in   1                     unpacker accepts command
//  beat_req_i    in   1                     unpacker issued a beat this cycle (already granted)
//  beat_eop_i    in   1                     that beat is the last of the transaction
//  trans_done_o  out  NB_PORTS              1-cycle pulse: owner's transaction fully issued
//  busy_o        out  1                     transaction in flight (ARB_BUSY)
// BEHAVIOUR
//  Reset values: in_gnt_o=0, cmd_req_o=0, cmd_* data=0, trans_done_o=0, busy_o=0.
//  Internal reset values: state=ARB_IDLE, rr_q=NB_PORTS-1, sel_q=0, owner_q=0.
//  Reset asserted mid-transaction drops all state; no done pulse is emitted for the aborted transaction.
//  Selection (combinational, only when not locked):
//   - first asserted in_req_i starting at index rr_q+1, wrapping modulo NB_PORTS.
//   - rr_q <= winner index on every cmd handshake.
//  Outputs: cmd_req_o = in_req_i[sel]; cmd_* = in_*[sel]; data = 0 when no request is pending.
//  in_gnt_o[sel] = cmd_gnt_i & cmd_req_o. Zero latency: command passes through in the same cycle.
//  FSM states:
//   - ARB_IDLE: no lock, nothing in flight.
//     - req and !cmd_gnt_i: sel_q <= sel -> ARB_WAIT.
//     - handshake with beat_req_i & beat_eop_i in the same cycle (single-beat command):
//       trans_done_o[sel]=1, stay in ARB_IDLE.
//     - handshake otherwise: owner_q <= sel -> ARB_BUSY.
//   - ARB_WAIT: selection frozen at sel_q, even if a higher-priority port requests.
//     - handshake: same rules as ARB_IDLE.
//     - in_req_i[sel_q] dropped (protocol violation): return to ARB_IDLE and re-arbitrate next cycle.
//   - ARB_BUSY: cmd_req_o is forwarded but cmd_gnt_i is 0 from the unpacker, so no handshake occurs.
//     - beat_req_i & beat_eop_i: trans_done_o[owner_q]=1 -> ARB_IDLE.
//     - A new command can be granted in the cycle after the done pulse.
//  Simultaneous requests: exactly one grant per cycle, never more.
//  With NB_PORTS=2 and both ports requesting continuously, grants strictly alternate.
//  beat_eop_i without beat_req_i is ignored.
// CONFIGURATION
//  TCDM_CMD_ARB_FIXED_PRIO_EN defined:
//   - search always starts at index 0 (lowest index wins); rr_q is not updated.
//   - lock (ARB_WAIT) and done tracking are unchanged.
//  Not defined: round-robin as described above.
// TESTING
//  1. Reset, port1 req (len=8, add=0x10), cmd_gnt_i=1, beat eop at +1 ->
//     in_gnt_o=2'b10, busy_o=1 one cycle, then trans_done_o=2'b10.
//  2. Both ports req, len=4, add=0x0, single-beat handshakes ->
//     grants 0,1,0,1 in consecutive cycles; trans_done_o matches each grant in the same cycle.
//  3. Port0 req with cmd_gnt_i=0 for 3 cycles, port1 raises req in cycle 2 ->
//     cmd_*=port0 fields held stable; port0 granted first.
//  4. Port0 granted len=32 (multi-beat); port1 reqs during ARB_BUSY ->
//     in_gnt_o=0 until beat_eop; port1 granted in the cycle after trans_done_o=2'b01.
//  5. rst_ni low while ARB_BUSY ->
//     all outputs 0 asynchronously; after release port0 has priority and no done pulse is emitted.
//  6. TCDM_CMD_ARB_FIXED_PRIO_EN, both ports req continuously, single-beat -> port0 granted every cycle.

Source files
------------

// File: rtl/tcdm_cmd_arbiter_if.sv
// Command-side bundle of tcdm_cmd_arbiter: per-port command inputs,
// the shared unpacker command/beat handshake, and per-port completion.
// slave  : the arbiter's view.
// master : the surrounding environment (command queues + unpacker).
interface tcdm_cmd_arbiter_if #(
  parameter int NB_PORTS        = 2,
  parameter int TRANS_SID_WIDTH = 2,
  parameter int TCDM_ADD_WIDTH  = 12,
  parameter int TCDM_OPC_WIDTH  = 12,
  parameter int MCHAN_LEN_WIDTH = 15
);
  // Per-port command requests
  logic [NB_PORTS-1:0][TCDM_OPC_WIDTH-1:0]  in_opc_i;
  logic [NB_PORTS-1:0][MCHAN_LEN_WIDTH-1:0] in_len_i;
  logic [NB_PORTS-1:0][TCDM_ADD_WIDTH-1:0]  in_add_i;
  logic [NB_PORTS-1:0][TRANS_SID_WIDTH-1:0] in_sid_i;
  logic [NB_PORTS-1:0]                      in_req_i;
  logic [NB_PORTS-1:0]                      in_gnt_o;

  // Selected command towards the unpacker
  logic [TCDM_OPC_WIDTH-1:0]  cmd_opc_o;
  logic [MCHAN_LEN_WIDTH-1:0] cmd_len_o;
  logic [TCDM_ADD_WIDTH-1:0]  cmd_add_o;
  logic [TRANS_SID_WIDTH-1:0] cmd_sid_o;
  logic                       cmd_req_o;
  logic                       cmd_gnt_i;

  // Beat progress reported back by the unpacker
  logic                       beat_req_i;
  logic                       beat_eop_i;

  // Completion / status
  logic [NB_PORTS-1:0]        trans_done_o;
  logic                       busy_o;

  modport slave (
    input  in_opc_i, in_len_i, in_add_i, in_sid_i, in_req_i,
    input  cmd_gnt_i, beat_req_i, beat_eop_i,
    output in_gnt_o, cmd_opc_o, cmd_len_o, cmd_add_o, cmd_sid_o, cmd_req_o,
    output trans_done_o, busy_o
  );

  modport master (
    output in_opc_i, in_len_i, in_add_i, in_sid_i, in_req_i,
    output cmd_gnt_i, beat_req_i, beat_eop_i,
    input  in_gnt_o, cmd_opc_o, cmd_len_o, cmd_add_o, cmd_sid_o, cmd_req_o,
    input  trans_done_o, busy_o
  );
endinterface

// File: rtl/tcdm_cmd_arbiter.sv
// tcdm_cmd_arbiter: shares one TCDM command unpacker between NB_PORTS
// command sources. Zero-latency pass-through of the selected command,
// lock on the selected port while the unpacker stalls, and tracking of
// the in-flight transaction until its end-of-packet beat.
// Build option: define TCDM_CMD_ARB_FIXED_PRIO_EN for fixed priority
// (lowest index wins); default is round-robin.
module tcdm_cmd_arbiter #(
  parameter int NB_PORTS        = 2,
  parameter int TRANS_SID_WIDTH = 2,
  parameter int TCDM_ADD_WIDTH  = 12,
  parameter int TCDM_OPC_WIDTH  = 12,
  parameter int MCHAN_LEN_WIDTH = 15
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  tcdm_cmd_arbiter_if.slave      bus
);

  localparam int IDX_W = (NB_PORTS > 1) ? $clog2(NB_PORTS) : 1;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_WAIT = 2'd1,
    ARB_BUSY = 2'd2
  } arb_state_e;

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] sel_q, sel_d;
  logic [IDX_W-1:0] owner_q, owner_d;
`ifdef TCDM_CMD_ARB_FIXED_PRIO_EN
`else
  logic [IDX_W-1:0] rr_q, rr_d;
`endif

  int               start_idx;
  logic [IDX_W-1:0] cand;
  logic [IDX_W-1:0] search_sel;
  logic             search_found;
  logic [IDX_W-1:0] sel;
  logic             req_sel;
  logic             hs;
  logic             eop_beat;

  // Search for the first pending request, starting after the last winner.
  always_comb begin
    // NOTE: every combinational variable gets a default first so no latch is inferred.
    search_sel   = '0;
    search_found = 1'b0;
    cand         = '0;
`ifdef TCDM_CMD_ARB_FIXED_PRIO_EN
    start_idx    = 0;
`else
    start_idx    = (int'(rr_q) + 1) % NB_PORTS;
`endif
    for (int k = 0; k < NB_PORTS; k++) begin
      cand = IDX_W'((start_idx + k) % NB_PORTS);
      if (!search_found && bus.in_req_i[cand]) begin
        search_found = 1'b1;
        search_sel   = cand;
      end
    end
  end

  // A stalled command keeps its port; a handshake is never taken while a
  // transaction is still being unpacked.
  assign sel      = (state_q == ARB_WAIT) ? sel_q : search_sel;
  assign req_sel  = bus.in_req_i[sel];
  assign eop_beat = bus.beat_req_i & bus.beat_eop_i;
  assign hs       = rst_ni & req_sel & bus.cmd_gnt_i & (state_q != ARB_BUSY);

  // Drive command, grant, done and busy outputs; everything reads zero while
  // rst_ni is low, including the combinational pass-through paths.
  always_comb begin
    bus.in_gnt_o     = '0;
    bus.cmd_req_o    = 1'b0;
    bus.cmd_opc_o    = '0;
    bus.cmd_len_o    = '0;
    bus.cmd_add_o    = '0;
    bus.cmd_sid_o    = '0;
    bus.trans_done_o = '0;
    bus.busy_o       = 1'b0;
    if (rst_ni) begin
      bus.cmd_req_o = req_sel;
      if (req_sel) begin
        bus.cmd_opc_o = bus.in_opc_i[sel];
        bus.cmd_len_o = bus.in_len_i[sel];
        bus.cmd_add_o = bus.in_add_i[sel];
        bus.cmd_sid_o = bus.in_sid_i[sel];
      end
      bus.in_gnt_o[sel] = hs;
      bus.busy_o        = (state_q == ARB_BUSY);
      if (hs && eop_beat) begin
        bus.trans_done_o[sel] = 1'b1;
      end else if ((state_q == ARB_BUSY) && eop_beat) begin
        bus.trans_done_o[owner_q] = 1'b1;
      end
    end
  end

  // Next-state logic: lock on stall, track owner until its end-of-packet beat.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    owner_d = owner_q;
`ifdef TCDM_CMD_ARB_FIXED_PRIO_EN
`else
    rr_d    = rr_q;
    if (hs) rr_d = sel;
`endif
    unique case (state_q)
      ARB_IDLE, ARB_WAIT: begin
        if (hs) begin
          if (eop_beat) begin
            state_d = ARB_IDLE;
          end else begin
            owner_d = sel;
            state_d = ARB_BUSY;
          end
        end else if (req_sel) begin
          sel_d   = sel;
          state_d = ARB_WAIT;
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_BUSY: begin
        if (eop_beat) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // State registers; reset drops any in-flight transaction silently.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ARB_IDLE;
      sel_q   <= '0;
      owner_q <= '0;
`ifdef TCDM_CMD_ARB_FIXED_PRIO_EN
`else
      rr_q    <= IDX_W'(NB_PORTS - 1);
`endif
    end else begin
      // NOTE: non-blocking assignments so all registers update together at the edge.
      state_q <= state_d;
      sel_q   <= sel_d;
      owner_q <= owner_d;
`ifdef TCDM_CMD_ARB_FIXED_PRIO_EN
`else
      rr_q    <= rr_d;
`endif
    end
  end

endmodule

// File: tb/tb_tcdm_cmd_arbiter.sv
// Self-checking bench for tcdm_cmd_arbiter (2 ports): directed scenarios
// followed by randomized traffic compared against a transaction-level model.
module tb_tcdm_cmd_arbiter;

  localparam int NP  = 2;
  localparam int IW  = 1;
  localparam int SID = 2;
  localparam int ADD = 12;
  localparam int OPC = 12;
  localparam int LEN = 15;
  localparam int OUT_W = 2*NP + 1 + OPC + LEN + ADD + SID + 1;

`ifdef TCDM_CMD_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  tcdm_cmd_arbiter_if #(
    .NB_PORTS(NP), .TRANS_SID_WIDTH(SID), .TCDM_ADD_WIDTH(ADD),
    .TCDM_OPC_WIDTH(OPC), .MCHAN_LEN_WIDTH(LEN)
  ) bus ();

  tcdm_cmd_arbiter #(
    .NB_PORTS(NP), .TRANS_SID_WIDTH(SID), .TCDM_ADD_WIDTH(ADD),
    .TCDM_OPC_WIDTH(OPC), .MCHAN_LEN_WIDTH(LEN)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [OUT_W-1:0] dut_outs;
  assign dut_outs = {bus.in_gnt_o, bus.cmd_req_o, bus.cmd_opc_o, bus.cmd_len_o,
                     bus.cmd_add_o, bus.cmd_sid_o, bus.trans_done_o, bus.busy_o};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_opc_i   = '0;
    bus.in_len_i   = '0;
    bus.in_add_i   = '0;
    bus.in_sid_i   = '0;
    bus.in_req_i   = '0;
    bus.cmd_gnt_i  = 1'b0;
    bus.beat_req_i = 1'b0;
    bus.beat_eop_i = 1'b0;
  endtask

  task automatic pulse_reset();
    idle_inputs();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    tick();
  endtask

  // Outputs are all zero under reset, even with every input active.
  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    bus.in_req_i   = 2'b11;
    bus.in_opc_i   = {12'h111, 12'h222};
    bus.cmd_gnt_i  = 1'b1;
    bus.beat_req_i = 1'b1;
    bus.beat_eop_i = 1'b1;
    #3;
    n_tests++;
    if (dut_outs !== '0) begin n_fail++; $display("FAIL reset_async: got %h expected 0", dut_outs); end
    tick();
    n_tests++;
    if (dut_outs !== '0) begin n_fail++; $display("FAIL reset_held: got %h expected 0", dut_outs); end
    idle_inputs();
    rst_n = 1'b1;
    #2;
    n_tests++;
    if (dut_outs !== '0) begin n_fail++; $display("FAIL reset_idle: got %h expected 0", dut_outs); end
    tick();
  endtask

  // Port1 alone, multi-beat command ending on the next cycle.
  task automatic test_single_port();
    bus.in_req_i    = 2'b10;
    bus.in_len_i[1] = 15'd8;
    bus.in_add_i[1] = 12'h010;
    bus.in_opc_i[1] = 12'h3C5;
    bus.in_sid_i[1] = 2'd2;
    bus.cmd_gnt_i   = 1'b1;
    #2;
    n_tests++;
    if (bus.in_gnt_o !== 2'b10) begin n_fail++; $display("FAIL t1_gnt: got %b expected 10", bus.in_gnt_o); end
    n_tests++;
    if ({bus.cmd_req_o, bus.cmd_len_o, bus.cmd_add_o, bus.cmd_opc_o, bus.cmd_sid_o} !== {1'b1, 15'd8, 12'h010, 12'h3C5, 2'd2}) begin
      n_fail++; $display("FAIL t1_cmd: got len=%0d add=%h opc=%h sid=%0d req=%b", bus.cmd_len_o, bus.cmd_add_o, bus.cmd_opc_o, bus.cmd_sid_o, bus.cmd_req_o);
    end
    tick();
    idle_inputs();
    bus.beat_req_i = 1'b1;
    bus.beat_eop_i = 1'b1;
    #2;
    n_tests++;
    if ({bus.busy_o, bus.trans_done_o} !== 3'b1_10) begin
      n_fail++; $display("FAIL t1_done: got busy=%b done=%b expected busy=1 done=10", bus.busy_o, bus.trans_done_o);
    end
    tick();
    idle_inputs();
    #2;
    n_tests++;
    if ({bus.busy_o, bus.trans_done_o} !== 3'b0_00) begin
      n_fail++; $display("FAIL t1_after: got busy=%b done=%b expected 0/00", bus.busy_o, bus.trans_done_o);
    end
    tick();
  endtask

  // Both ports request continuously with single-beat commands.
  task automatic test_alternate();
    logic [NP-1:0] exp_g;
    bus.in_req_i   = 2'b11;
    bus.in_len_i   = {15'd4, 15'd4};
    bus.in_add_i   = '0;
    bus.cmd_gnt_i  = 1'b1;
    bus.beat_req_i = 1'b1;
    bus.beat_eop_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      exp_g = (FIXED || (c % 2 == 0)) ? 2'b01 : 2'b10;
      #2;
      n_tests++;
      if (bus.in_gnt_o !== exp_g) begin n_fail++; $display("FAIL t2_gnt[%0d]: got %b expected %b", c, bus.in_gnt_o, exp_g); end
      n_tests++;
      if (bus.trans_done_o !== exp_g) begin n_fail++; $display("FAIL t2_done[%0d]: got %b expected %b", c, bus.trans_done_o, exp_g); end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  // A stalled port0 command stays selected although port1 would win.
  task automatic test_wait_lock();
    bus.in_req_i   = 2'b01;
    bus.cmd_gnt_i  = 1'b1;
    bus.beat_req_i = 1'b1;
    bus.beat_eop_i = 1'b1;
    #2;
    n_tests++;
    if (bus.in_gnt_o !== 2'b01) begin n_fail++; $display("FAIL t3_prime: got %b expected 01", bus.in_gnt_o); end
    tick();
    idle_inputs();
    bus.in_req_i    = 2'b01;
    bus.in_opc_i[0] = 12'hA5A;
    bus.in_opc_i[1] = 12'h5B5;
    for (int c = 0; c < 3; c++) begin
      if (c >= 1) bus.in_req_i = 2'b11;
      #2;
      n_tests++;
      if ({bus.cmd_req_o, bus.cmd_opc_o, bus.in_gnt_o} !== {1'b1, 12'hA5A, 2'b00}) begin
        n_fail++; $display("FAIL t3_hold[%0d]: got req=%b opc=%h gnt=%b expected 1/a5a/00", c, bus.cmd_req_o, bus.cmd_opc_o, bus.in_gnt_o);
      end
      tick();
    end
    bus.cmd_gnt_i  = 1'b1;
    bus.beat_req_i = 1'b1;
    bus.beat_eop_i = 1'b1;
    #2;
    n_tests++;
    if ({bus.in_gnt_o, bus.trans_done_o} !== 4'b01_01) begin
      n_fail++; $display("FAIL t3_grant: got gnt=%b done=%b expected 01/01", bus.in_gnt_o, bus.trans_done_o);
    end
    tick();
    bus.in_req_i = 2'b10;
    #2;
    n_tests++;
    if (bus.in_gnt_o !== 2'b10) begin n_fail++; $display("FAIL t3_next: got %b expected 10", bus.in_gnt_o); end
    tick();
    idle_inputs();
    tick();
  endtask

  // Port1 must wait for port0's multi-beat transaction to finish.
  task automatic test_busy();
    bus.in_req_i    = 2'b01;
    bus.in_len_i[0] = 15'd32;
    bus.cmd_gnt_i   = 1'b1;
    #2;
    n_tests++;
    if (bus.in_gnt_o !== 2'b01) begin n_fail++; $display("FAIL t4_gnt0: got %b expected 01", bus.in_gnt_o); end
    tick();
    bus.in_req_i  = 2'b10;
    bus.cmd_gnt_i = 1'b0;
    for (int c = 0; c < 2; c++) begin
      bus.beat_req_i = (c == 1);
      bus.beat_eop_i = (c == 0);
      #2;
      n_tests++;
      if ({bus.in_gnt_o, bus.trans_done_o, bus.busy_o} !== 5'b00_00_1) begin
        n_fail++; $display("FAIL t4_busy[%0d]: got gnt=%b done=%b busy=%b expected 00/00/1", c, bus.in_gnt_o, bus.trans_done_o, bus.busy_o);
      end
      tick();
    end
    bus.beat_req_i = 1'b1;
    bus.beat_eop_i = 1'b1;
    #2;
    n_tests++;
    if ({bus.in_gnt_o, bus.trans_done_o} !== 4'b00_01) begin
      n_fail++; $display("FAIL t4_eop: got gnt=%b done=%b expected 00/01", bus.in_gnt_o, bus.trans_done_o);
    end
    tick();
    bus.beat_req_i = 1'b0;
    bus.beat_eop_i = 1'b0;
    bus.cmd_gnt_i  = 1'b1;
    #2;
    n_tests++;
    if ({bus.in_gnt_o, bus.busy_o} !== 3'b10_0) begin
      n_fail++; $display("FAIL t4_gnt1: got gnt=%b busy=%b expected 10/0", bus.in_gnt_o, bus.busy_o);
    end
    tick();
    idle_inputs();
    bus.beat_req_i = 1'b1;
    bus.beat_eop_i = 1'b1;
    #2;
    n_tests++;
    if (bus.trans_done_o !== 2'b10) begin n_fail++; $display("FAIL t4_done1: got %b expected 10", bus.trans_done_o); end
    tick();
    idle_inputs();
    tick();
  endtask

  // Reset during a transaction: outputs drop at once, no stale done pulse.
  task automatic test_reset_mid();
    bus.in_req_i  = 2'b01;
    bus.cmd_gnt_i = 1'b1;
    tick();
    bus.in_req_i   = 2'b11;
    bus.cmd_gnt_i  = 1'b0;
    bus.beat_req_i = 1'b1;
    bus.beat_eop_i = 1'b1;
    rst_n = 1'b0;
    #2;
    n_tests++;
    if (dut_outs !== '0) begin n_fail++; $display("FAIL t5_async: got %h expected 0", dut_outs); end
    tick();
    bus.in_req_i = 2'b00;
    rst_n = 1'b1;
    #2;
    n_tests++;
    if ({bus.trans_done_o, bus.busy_o} !== 3'b00_0) begin
      n_fail++; $display("FAIL t5_nodone: got done=%b busy=%b expected 00/0", bus.trans_done_o, bus.busy_o);
    end
    tick();
    bus.in_req_i   = 2'b11;
    bus.cmd_gnt_i  = 1'b1;
    bus.beat_req_i = 1'b0;
    bus.beat_eop_i = 1'b0;
    #2;
    n_tests++;
    if (bus.in_gnt_o !== 2'b01) begin n_fail++; $display("FAIL t5_prio: got %b expected 01", bus.in_gnt_o); end
    tick();
    idle_inputs();
    bus.beat_req_i = 1'b1;
    bus.beat_eop_i = 1'b1;
    #2;
    n_tests++;
    if (bus.trans_done_o !== 2'b01) begin n_fail++; $display("FAIL t5_done: got %b expected 01", bus.trans_done_o); end
    tick();
    idle_inputs();
    tick();
  endtask

  // Winner among pending requests: scan starting after the last winner.
  function automatic int model_pick(input logic [NP-1:0] req, input int last);
    int start;
    start = FIXED ? 0 : (last + 1) % NP;
    for (int k = 0; k < NP; k++) begin
      if (req[IW'((start + k) % NP)]) return (start + k) % NP;
    end
    return -1;
  endfunction

  // Random traffic against a transaction-level model of the arbiter.
  task automatic test_random();
    int m_last = NP - 1;
    bit m_locked = 1'b0;
    int m_lock = 0;
    bit m_busy = 1'b0;
    int m_owner = 0;
    int cand;
    bit e_req, e_hs, eop;
    logic [NP-1:0] e_gnt, e_done;
    logic [OPC-1:0] e_opc;
    logic [LEN-1:0] e_len;
    logic [ADD-1:0] e_add;
    logic [SID-1:0] e_sid;
    logic [OUT_W-1:0] exp_v;
    pulse_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int p = 0; p < NP; p++) begin
        bus.in_req_i[IW'(p)] = ($urandom_range(0, 3) != 0);
        bus.in_opc_i[IW'(p)] = OPC'($urandom);
        bus.in_len_i[IW'(p)] = LEN'($urandom);
        bus.in_add_i[IW'(p)] = ADD'($urandom);
        bus.in_sid_i[IW'(p)] = SID'($urandom);
      end
      bus.cmd_gnt_i  = !m_busy && ($urandom_range(0, 2) != 0);
      bus.beat_req_i = ($urandom_range(0, 1) != 0);
      bus.beat_eop_i = ($urandom_range(0, 1) != 0);
      #2;
      eop    = bus.beat_req_i && bus.beat_eop_i;
      cand   = m_locked ? m_lock : model_pick(bus.in_req_i, m_last);
      e_req  = (cand >= 0) && bus.in_req_i[IW'(cand)];
      e_gnt  = '0;
      e_done = '0;
      e_opc  = '0;
      e_len  = '0;
      e_add  = '0;
      e_sid  = '0;
      if (e_req) begin
        e_opc = bus.in_opc_i[IW'(cand)];
        e_len = bus.in_len_i[IW'(cand)];
        e_add = bus.in_add_i[IW'(cand)];
        e_sid = bus.in_sid_i[IW'(cand)];
      end
      e_hs = e_req && bus.cmd_gnt_i && !m_busy;
      if (e_hs) e_gnt[IW'(cand)] = 1'b1;
      if (m_busy) begin
        if (eop) e_done[IW'(m_owner)] = 1'b1;
      end else if (e_hs && eop) begin
        e_done[IW'(cand)] = 1'b1;
      end
      exp_v = {e_gnt, e_req, e_opc, e_len, e_add, e_sid, e_done, m_busy};
      n_tests++;
      if (dut_outs !== exp_v) begin
        n_fail++; $display("FAIL rand[%0d]: got %h expected %h", cyc, dut_outs, exp_v);
      end
      if (m_busy) begin
        if (eop) m_busy = 1'b0;
      end else if (e_hs) begin
        m_locked = 1'b0;
        if (!FIXED) m_last = cand;
        if (!eop) begin
          m_busy  = 1'b1;
          m_owner = cand;
        end
      end else if (e_req) begin
        m_locked = 1'b1;
        m_lock   = cand;
      end else begin
        m_locked = 1'b0;
      end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_single_port();
    test_alternate();
    test_wait_lock();
    test_busy();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
